// File: rtl/alarm_display_ctrl.sv
// Level-meter alarm annunciator: debounces the alarm code, runs the ack FSM,
// and scans a right-aligned 7-segment word across NUM_DIGITS digits.
module alarm_display_ctrl #(
    parameter int NUM_DIGITS     = 4,
    parameter int SCAN_DIV       = 50000,
    parameter int BLINK_DIV      = 25000000,
    parameter int STABLE_CYCLES  = 16,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit DIG_ACTIVE_LOW = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [2:0]            alarm_code,
    input  logic                  ack,
    output logic [7:0]            seg,
    output logic [NUM_DIGITS-1:0] digit_en,
    output logic                  alarm_active,
    output logic                  alarm_unack
);

    localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int SCAN_W  = $clog2(SCAN_DIV);
    localparam int BLINK_W = $clog2(BLINK_DIV);
    localparam int STAB_W  = $clog2(STABLE_CYCLES);

    localparam logic [IDX_W-1:0]   IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
    localparam logic [SCAN_W-1:0]  SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
    localparam logic [BLINK_W-1:0] BLNK_LAST = BLINK_W'(BLINK_DIV - 1);
    localparam logic [STAB_W-1:0]  STAB_LAST = STAB_W'(STABLE_CYCLES - 1);

    // Glyphs in active-low form; dp (LSB) is always off.
    localparam logic [7:0] G_L     = 8'b1110_0011;
    localparam logic [7:0] G_O     = 8'b1100_0101;
    localparam logic [7:0] G_H     = 8'b1001_0001;
    localparam logic [7:0] G_I     = 8'b1001_1111;
    localparam logic [7:0] G_E     = 8'b0110_0001;
    localparam logic [7:0] G_R     = 8'b1111_0101;
    localparam logic [7:0] G_BLANK = 8'b1111_1111;

    localparam logic [7:0] SEG_OFF =
        SEG_ACTIVE_LOW ? 8'hFF : 8'h00;
    localparam logic [NUM_DIGITS-1:0] DIG_OFF =
        DIG_ACTIVE_LOW ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};

    typedef enum logic [2:0] {
        CLS_NORMAL,
        CLS_LOW,
        CLS_HIGH,
        CLS_ERROR,
        CLS_INVALID
    } cls_t;

    typedef enum logic [1:0] {
        ST_NORMAL,
        ST_ALARM_UNACK,
        ST_ALARM_ACK
    } state_t;

    function automatic cls_t classify(input logic [2:0] c);
        cls_t r;
        case (c)
            3'b000:                   r = CLS_NORMAL;
            3'b001:                   r = CLS_LOW;
            3'b010:                   r = CLS_HIGH;
            3'b100, 3'b101, 3'b110:   r = CLS_ERROR;
            default:                  r = CLS_INVALID;
        endcase
        return r;
    endfunction

    logic [2:0]         code_q;
    logic [STAB_W-1:0]  stab_cnt;
    cls_t               cls;
    cls_t               cls_nxt;
    logic               latch_en;
    logic               cls_chg;
    logic               nxt_is_alarm;

    state_t             state;

    logic [SCAN_W-1:0]  scan_cnt;
    logic [IDX_W-1:0]   scan_idx;
    logic [BLINK_W-1:0] blink_cnt;
    logic               blink_phase;

    logic [3:0]            pos;
    logic [7:0]            glyph;
    logic [7:0]            seg_int;
    logic [NUM_DIGITS-1:0] onehot;

    assign cls_nxt  = classify(code_q);
    assign latch_en = (alarm_code == code_q) && (stab_cnt == STAB_LAST);
    assign cls_chg  = latch_en && (cls_nxt != cls);

    assign nxt_is_alarm = (cls_nxt == CLS_LOW)  ||
                          (cls_nxt == CLS_HIGH) ||
                          (cls_nxt == CLS_ERROR);

    // Any sample that differs from the previous one restarts the count.
    always_ff @(posedge clk) begin
        if (reset) begin
            code_q   <= 3'b000;
            stab_cnt <= '0;
            cls      <= CLS_INVALID;
        end else begin
            code_q <= alarm_code;
            if (alarm_code != code_q) begin
                stab_cnt <= '0;
            end else if (stab_cnt != STAB_LAST) begin
                stab_cnt <= stab_cnt + 1'b1;
            end
            if (latch_en) begin
                cls <= cls_nxt;
            end
        end
    end

    // A class change outranks a coincident ack.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ST_NORMAL;
            alarm_active <= 1'b0;
            alarm_unack  <= 1'b0;
        end else if (cls_chg) begin
            if (nxt_is_alarm) begin
                state        <= ST_ALARM_UNACK;
                alarm_active <= 1'b1;
                alarm_unack  <= 1'b1;
            end else begin
                state        <= ST_NORMAL;
                alarm_active <= 1'b0;
                alarm_unack  <= 1'b0;
            end
        end else if (state == ST_ALARM_UNACK && ack) begin
            state        <= ST_ALARM_ACK;
            alarm_active <= 1'b1;
            alarm_unack  <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            scan_cnt <= '0;
            scan_idx <= '0;
        end else if (scan_cnt == SCAN_LAST) begin
            scan_cnt <= '0;
            if (scan_idx == IDX_LAST) begin
                scan_idx <= '0;
            end else begin
                scan_idx <= scan_idx + 1'b1;
            end
        end else begin
            scan_cnt <= scan_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (blink_cnt == BLNK_LAST) begin
            blink_cnt   <= '0;
            blink_phase <= ~blink_phase;
        end else begin
            blink_cnt <= blink_cnt + 1'b1;
        end
    end

    assign pos = 4'(scan_idx);

    // Messages are right-aligned: position 0 is the rightmost digit.
    always_comb begin
        glyph = G_BLANK;
        case (cls)
            CLS_NORMAL: begin
                if (pos == 4'd0) glyph = G_O;
            end
            CLS_LOW: begin
                if (pos == 4'd0)      glyph = G_O;
                else if (pos == 4'd1) glyph = G_L;
            end
            CLS_HIGH: begin
                if (pos == 4'd0)      glyph = G_I;
                else if (pos == 4'd1) glyph = G_H;
            end
            CLS_ERROR: begin
                if (pos == 4'd0)      glyph = G_R;
                else if (pos == 4'd1) glyph = G_R;
                else if (pos == 4'd2) glyph = G_E;
            end
            default: glyph = G_BLANK;
        endcase
    end

    always_comb begin
        seg_int = glyph;
        if (state == ST_ALARM_UNACK && blink_phase) begin
            seg_int = G_BLANK;
        end
    end

    assign onehot = NUM_DIGITS'(1) << scan_idx;

    // seg and digit_en share one register stage so they never disagree.
    always_ff @(posedge clk) begin
        if (reset) begin
            seg      <= SEG_OFF;
            digit_en <= DIG_OFF;
        end else begin
            seg      <= SEG_ACTIVE_LOW ? seg_int : ~seg_int;
            digit_en <= DIG_ACTIVE_LOW ? ~onehot : onehot;
        end
    end

endmodule

// File: tb/tb_alarm_display_ctrl.sv
// Directed bench for alarm_display_ctrl: debounce, classification,
// ack FSM, blink and digit scanning with small dividers.
module tb_alarm_display_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] alarm_code;
    logic       ack;
    logic [7:0] seg;
    logic [3:0] digit_en;
    logic       alarm_active;
    logic       alarm_unack;

    int nvec = 0;
    int nerr = 0;
    int cyc  = 0;

    localparam logic [7:0] GL = 8'hE3;
    localparam logic [7:0] GO = 8'hC5;
    localparam logic [7:0] GH = 8'h91;
    localparam logic [7:0] GI = 8'h9F;
    localparam logic [7:0] GE = 8'h61;
    localparam logic [7:0] GR = 8'hF5;
    localparam logic [7:0] GB = 8'hFF;

    alarm_display_ctrl #(
        .NUM_DIGITS     (4),
        .SCAN_DIV       (4),
        .BLINK_DIV      (16),
        .STABLE_CYCLES  (8),
        .SEG_ACTIVE_LOW (1'b1),
        .DIG_ACTIVE_LOW (1'b1)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .alarm_code   (alarm_code),
        .ack          (ack),
        .seg          (seg),
        .digit_en     (digit_en),
        .alarm_active (alarm_active),
        .alarm_unack  (alarm_unack)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Edge k after reset release shows the digit selected during edge k-1.
    function automatic logic [3:0] exp_dig(input int k);
        int idx;
        logic [3:0] d;
        idx = ((k - 1) / 4) % 4;
        d = 4'hF;
        d[idx] = 1'b0;
        return d;
    endfunction

    function automatic logic [7:0] exp_seg(
        input int k,
        input logic [7:0] g3, input logic [7:0] g2,
        input logic [7:0] g1, input logic [7:0] g0,
        input bit blink
    );
        int idx;
        idx = ((k - 1) / 4) % 4;
        if (blink && (((k - 1) / 16) % 2 == 1)) return GB;
        case (idx)
            0: return g0;
            1: return g1;
            2: return g2;
            default: return g3;
        endcase
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        alarm_code = 3'b000;
        ack = 1'b0;
        step();
        step();
        nvec++;
        if (seg !== 8'hFF) begin
            nerr++;
            $display("FAIL rst_seg got=%h exp=ff", seg);
        end
        nvec++;
        if (digit_en !== 4'hF) begin
            nerr++;
            $display("FAIL rst_dig got=%b exp=1111", digit_en);
        end
        nvec++;
        if ({alarm_active, alarm_unack} !== 2'b00) begin
            nerr++;
            $display("FAIL rst_flags got=%b exp=00",
                     {alarm_active, alarm_unack});
        end
        reset = 1'b0;
        cyc = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            nvec++;
            if (seg !== 8'hFF || digit_en !== exp_dig(cyc)) begin
                nerr++;
                $display("FAIL t1_pre cyc=%0d got=%h/%b exp=ff/%b",
                         cyc, seg, digit_en, exp_dig(cyc));
            end
        end
        for (int i = 0; i < 32; i++) begin
            step();
            nvec++;
            if (digit_en !== exp_dig(cyc) ||
                seg !== exp_seg(cyc, GB, GB, GB, GO, 1'b0) ||
                alarm_active !== 1'b0) begin
                nerr++;
                $display("FAIL t1_o cyc=%0d got=%h/%b/%b exp=%h/%b/0",
                         cyc, seg, digit_en, alarm_active,
                         exp_seg(cyc, GB, GB, GB, GO, 1'b0),
                         exp_dig(cyc));
            end
        end
    endtask

    task automatic test_low_blink();
        alarm_code = 3'b001;
        for (int i = 0; i < 8; i++) step();
        nvec++;
        if (alarm_unack !== 1'b0) begin
            nerr++;
            $display("FAIL t2_early got=%b exp=0", alarm_unack);
        end
        step();
        nvec++;
        if ({alarm_active, alarm_unack} !== 2'b11) begin
            nerr++;
            $display("FAIL t2_unack got=%b exp=11",
                     {alarm_active, alarm_unack});
        end
        for (int i = 0; i < 48; i++) begin
            step();
            nvec++;
            if (digit_en !== exp_dig(cyc) ||
                seg !== exp_seg(cyc, GB, GB, GL, GO, 1'b1)) begin
                nerr++;
                $display("FAIL t2_lo cyc=%0d got=%h/%b exp=%h/%b",
                         cyc, seg, digit_en,
                         exp_seg(cyc, GB, GB, GL, GO, 1'b1),
                         exp_dig(cyc));
            end
        end
    endtask

    task automatic test_ack_then_high();
        ack = 1'b1;
        step();
        ack = 1'b0;
        nvec++;
        if ({alarm_active, alarm_unack} !== 2'b10) begin
            nerr++;
            $display("FAIL t3_ack got=%b exp=10",
                     {alarm_active, alarm_unack});
        end
        for (int i = 0; i < 40; i++) begin
            step();
            nvec++;
            if (digit_en !== exp_dig(cyc) ||
                seg !== exp_seg(cyc, GB, GB, GL, GO, 1'b0)) begin
                nerr++;
                $display("FAIL t3_steady cyc=%0d got=%h/%b exp=%h/%b",
                         cyc, seg, digit_en,
                         exp_seg(cyc, GB, GB, GL, GO, 1'b0),
                         exp_dig(cyc));
            end
        end
        alarm_code = 3'b010;
        for (int i = 0; i < 8; i++) step();
        nvec++;
        if ({alarm_active, alarm_unack} !== 2'b10) begin
            nerr++;
            $display("FAIL t3_hold got=%b exp=10",
                     {alarm_active, alarm_unack});
        end
        step();
        nvec++;
        if ({alarm_active, alarm_unack} !== 2'b11) begin
            nerr++;
            $display("FAIL t3_reunack got=%b exp=11",
                     {alarm_active, alarm_unack});
        end
        for (int i = 0; i < 40; i++) begin
            step();
            nvec++;
            if (digit_en !== exp_dig(cyc) ||
                seg !== exp_seg(cyc, GB, GB, GH, GI, 1'b1)) begin
                nerr++;
                $display("FAIL t3_hi cyc=%0d got=%h/%b exp=%h/%b",
                         cyc, seg, digit_en,
                         exp_seg(cyc, GB, GB, GH, GI, 1'b1),
                         exp_dig(cyc));
            end
        end
    endtask

    task automatic test_glitch_err_invalid();
        alarm_code = 3'b000;
        for (int i = 0; i < 9; i++) step();
        nvec++;
        if ({alarm_active, alarm_unack} !== 2'b00) begin
            nerr++;
            $display("FAIL t4_norm got=%b exp=00",
                     {alarm_active, alarm_unack});
        end
        ack = 1'b1;
        step();
        ack = 1'b0;
        alarm_code = 3'b100;
        for (int i = 0; i < 5; i++) step();
        alarm_code = 3'b000;
        for (int i = 0; i < 12; i++) begin
            step();
            nvec++;
            if ({alarm_active, alarm_unack} !== 2'b00) begin
                nerr++;
                $display("FAIL t4_glitch cyc=%0d got=%b exp=00",
                         cyc, {alarm_active, alarm_unack});
            end
        end
        for (int i = 0; i < 20; i++) begin
            step();
            nvec++;
            if (digit_en !== exp_dig(cyc) ||
                seg !== exp_seg(cyc, GB, GB, GB, GO, 1'b0)) begin
                nerr++;
                $display("FAIL t4_o cyc=%0d got=%h/%b exp=%h/%b",
                         cyc, seg, digit_en,
                         exp_seg(cyc, GB, GB, GB, GO, 1'b0),
                         exp_dig(cyc));
            end
        end
        alarm_code = 3'b110;
        for (int i = 0; i < 9; i++) step();
        nvec++;
        if ({alarm_active, alarm_unack} !== 2'b11) begin
            nerr++;
            $display("FAIL t4_err got=%b exp=11",
                     {alarm_active, alarm_unack});
        end
        for (int i = 0; i < 40; i++) begin
            step();
            nvec++;
            if (digit_en !== exp_dig(cyc) ||
                seg !== exp_seg(cyc, GB, GE, GR, GR, 1'b1)) begin
                nerr++;
                $display("FAIL t4_errdisp cyc=%0d got=%h/%b exp=%h/%b",
                         cyc, seg, digit_en,
                         exp_seg(cyc, GB, GE, GR, GR, 1'b1),
                         exp_dig(cyc));
            end
        end
        alarm_code = 3'b011;
        for (int i = 0; i < 9; i++) step();
        nvec++;
        if ({alarm_active, alarm_unack} !== 2'b00) begin
            nerr++;
            $display("FAIL t4_inv got=%b exp=00",
                     {alarm_active, alarm_unack});
        end
        for (int i = 0; i < 20; i++) begin
            step();
            nvec++;
            if (digit_en !== exp_dig(cyc) || seg !== 8'hFF) begin
                nerr++;
                $display("FAIL t4_blank cyc=%0d got=%h/%b exp=ff/%b",
                         cyc, seg, digit_en, exp_dig(cyc));
            end
        end
    endtask

    task automatic test_ack_race();
        alarm_code = 3'b001;
        for (int i = 0; i < 9; i++) step();
        ack = 1'b1;
        step();
        ack = 1'b0;
        nvec++;
        if ({alarm_active, alarm_unack} !== 2'b10) begin
            nerr++;
            $display("FAIL t5_ack got=%b exp=10",
                     {alarm_active, alarm_unack});
        end
        alarm_code = 3'b100;
        for (int i = 0; i < 8; i++) step();
        nvec++;
        if ({alarm_active, alarm_unack} !== 2'b10) begin
            nerr++;
            $display("FAIL t5_pre got=%b exp=10",
                     {alarm_active, alarm_unack});
        end
        ack = 1'b1;
        step();
        ack = 1'b0;
        nvec++;
        if ({alarm_active, alarm_unack} !== 2'b11) begin
            nerr++;
            $display("FAIL t5_race got=%b exp=11",
                     {alarm_active, alarm_unack});
        end
    endtask

    task automatic test_reset_mid();
        ack = 1'b1;
        step();
        ack = 1'b0;
        nvec++;
        if ({alarm_active, alarm_unack} !== 2'b10) begin
            nerr++;
            $display("FAIL t6_ack got=%b exp=10",
                     {alarm_active, alarm_unack});
        end
        reset = 1'b1;
        step();
        nvec++;
        if (seg !== 8'hFF || digit_en !== 4'hF ||
            {alarm_active, alarm_unack} !== 2'b00) begin
            nerr++;
            $display("FAIL t6_rst got=%h/%b/%b exp=ff/1111/00",
                     seg, digit_en, {alarm_active, alarm_unack});
        end
        reset = 1'b0;
        cyc = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            nvec++;
            if (alarm_unack !== 1'b0 || seg !== 8'hFF) begin
                nerr++;
                $display("FAIL t6_deb cyc=%0d got=%b/%h exp=0/ff",
                         cyc, alarm_unack, seg);
            end
        end
        step();
        nvec++;
        if ({alarm_active, alarm_unack} !== 2'b11) begin
            nerr++;
            $display("FAIL t6_reenter got=%b exp=11",
                     {alarm_active, alarm_unack});
        end
        for (int i = 0; i < 32; i++) begin
            step();
            nvec++;
            if (digit_en !== exp_dig(cyc) ||
                seg !== exp_seg(cyc, GB, GE, GR, GR, 1'b1)) begin
                nerr++;
                $display("FAIL t6_err cyc=%0d got=%h/%b exp=%h/%b",
                         cyc, seg, digit_en,
                         exp_seg(cyc, GB, GE, GR, GR, 1'b1),
                         exp_dig(cyc));
            end
        end
    endtask

    initial begin
        test_reset();
        test_low_blink();
        test_ack_then_high();
        test_glitch_err_invalid();
        test_ack_race();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
